// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_unit
//  Purpose  : Instruction fetch stage. Issues sequential word fetches to
//             instruction memory, buffers the returned instructions together
//             with their PCs in a small prefetch FIFO, and hands them to
//             decode. A redirect flushes the FIFO and restarts fetch at a
//             new PC. Responses still in flight at that point are discarded
//             as they return.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   core clock, rising edge
//    areset         in   asynchronous reset, active low
//    imem_req_*     out/in  request channel (valid/ready, word address)
//    imem_rsp_*     in   in-order response channel (valid, data)
//    redirect_*     in   flush and restart fetch at redirect_pc
//    inst_*         out/in  FIFO head toward decode (valid/ready, data, pc)
//    fetch_idle     out  nothing outstanding, FIFO empty, out of boot
// ============================================================================
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        areset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_idle
);

  localparam int             c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] c_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_rsp_pc;       // PC of the oldest outstanding live request
  logic [CNT_W-1:0]   r_outstanding;  // all requests awaiting a response
  logic [CNT_W-1:0]   r_drop_cnt;     // how many of those are stale
  logic [CNT_W-1:0]   r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [31:0]        r_fifo_data [FIFO_DEPTH];
  logic [31:0]        r_fifo_pc   [FIFO_DEPTH];

  logic               w_credit;
  logic               w_req_fire;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_redirect_pc;
  logic [CNT_W-1:0]   w_outst_next;
  logic [CNT_W-1:0]   w_drop_next;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  // Buffered plus in-flight never exceeds the FIFO depth, so every response
  // that returns is guaranteed a free slot.
  assign w_credit       = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_DEPTH;
  assign imem_req_valid = (r_state != ST_BOOT) && w_credit && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_drop = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push = imem_rsp_valid && !w_drop && !redirect_valid;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    w_outst_next = r_outstanding;
    if (w_req_fire) begin
      w_outst_next = w_outst_next + CNT_W'(1);
    end
    if (imem_rsp_valid) begin
      w_outst_next = w_outst_next - CNT_W'(1);
    end
  end

  // After a redirect every request still in flight is stale, so the drop
  // count becomes the full post-cycle outstanding count. This equals the old
  // drop count plus the live requests, and a response arriving in the
  // redirect cycle is already excluded (and itself never pushed).
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (redirect_valid) begin
      w_drop_next = w_outst_next;
    end else if (w_drop) begin
      w_drop_next = r_drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_outst_next;
      r_drop_cnt    <= w_drop_next;

      if (r_state == ST_BOOT) begin
        r_state <= ST_RUN;
      end else if (w_drop_next != '0) begin
        r_state <= ST_DRAIN;
      end else begin
        r_state <= ST_RUN;
      end

      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO holds data.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst_data  = inst_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'd0;
  assign fetch_idle = (r_state != ST_BOOT) && (r_outstanding == '0) && (r_count == '0);

endmodule
`default_nettype wire
